// File: rtl/dsm_pkg.sv
// Shared widths, per-operand segment result type and the segment extraction helper
// for the dynamic-segment multiplier front end.
package dsm_pkg;

    localparam int WIDTH = 16;
    localparam int SEG   = 8;
    localparam int SHW   = 4;

    typedef struct packed {
        logic [SEG-1:0] seg;
        logic [SHW-1:0] shift;
        logic           sel;
        logic           zero_x;
        logic           trunc_x;
    } seg_res_t;

    // Window of SEG bits ending at the leading one; any bits shifted out set the
    // segment LSB so the approximate product is biased toward the true value.
    function automatic seg_res_t seg_extract(input logic [WIDTH-1:0] x,
                                             input logic [SHW-1:0]   p,
                                             input logic             nz);
        seg_res_t         r;
        logic [WIDTH-1:0] w_sh;
        logic [WIDTH-1:0] w_mask;
        r      = '0;
        w_sh   = '0;
        w_mask = '0;
        if (nz) begin
            if (p >= SHW'(SEG)) begin
                r.shift = p - SHW'(SEG - 1);
            end
            w_sh      = x >> r.shift;
            w_mask    = ~({WIDTH{1'b1}} << r.shift);
            r.seg     = w_sh[SEG-1:0];
            r.trunc_x = |(x & w_mask);
            r.seg[0]  = r.seg[0] | r.trunc_x;
            r.sel     = (r.shift != '0);
        end else begin
            r.zero_x  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsm_segment_stage_lod16.sv
// Combinational leading-one detector: p is the index of the highest set bit of x,
// nz flags a nonzero input (p is 0 when x is 0).
module lod16
    import dsm_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    output logic [SHW-1:0]   p,
    output logic             nz
);

    always_comb begin
        p  = '0;
        nz = |x;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                p = SHW'(i);
            end
        end
    end

endmodule

// File: rtl/dsm_segment_stage.sv
// Operand segmentation front end: 2 registered stages (operands, then segments); 2-cycle latency.
// Each stage loads when empty or draining; in_ready is combinational from out_ready.
module dsm_segment_stage #(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEG-1:0]   seg_a,
    output logic [SEG-1:0]   seg_b,
    output logic [3:0]       shift_a,
    output logic [3:0]       shift_b,
    output logic             sel_a,
    output logic             sel_b,
    output logic             zero,
    output logic             trunc
);
    import dsm_pkg::SHW;
    import dsm_pkg::seg_res_t;
    import dsm_pkg::seg_extract;

    logic             r_s1_v;
    logic             r_s2_v;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    seg_res_t         r_res_a;
    seg_res_t         r_res_b;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [SHW-1:0]   w_p_a;
    logic [SHW-1:0]   w_p_b;
    logic             w_nz_a;
    logic             w_nz_b;
    seg_res_t         w_res_a;
    seg_res_t         w_res_b;

    // Stage 1 may refill whenever stage 2 is pulling its contents this cycle.
    assign w_s2_load = ~r_s2_v | out_ready;
    assign w_s1_load = ~r_s1_v | w_s2_load;
    assign in_ready  = w_s1_load;

    lod16 u_lod_a (
        .x  (r_a),
        .p  (w_p_a),
        .nz (w_nz_a)
    );

    lod16 u_lod_b (
        .x  (r_b),
        .p  (w_p_b),
        .nz (w_nz_b)
    );

    always_comb begin
        w_res_a = seg_extract(r_a, w_p_a, w_nz_a);
        w_res_b = seg_extract(r_b, w_p_b, w_nz_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v  <= 1'b0;
            r_s2_v  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res_a <= '0;
            r_res_b <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_res_a <= w_res_a;
                    r_res_b <= w_res_b;
                end
            end
            if (w_s1_load) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_a <= a;
                    r_b <= b;
                end
            end
        end
    end

    assign out_valid = r_s2_v;
    assign seg_a     = r_res_a.seg;
    assign seg_b     = r_res_b.seg;
    assign shift_a   = r_res_a.shift;
    assign shift_b   = r_res_b.shift;
    assign sel_a     = r_res_a.sel;
    assign sel_b     = r_res_b.sel;
    assign zero      = r_res_a.zero_x | r_res_b.zero_x;
    assign trunc     = r_res_a.trunc_x | r_res_b.trunc_x;

endmodule

// File: tb/tb_dsm_segment_stage.sv
// Directed plus randomized bench for dsm_segment_stage with an arithmetic reference model.
module tb_dsm_segment_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  seg_a;
    logic [7:0]  seg_b;
    logic [3:0]  shift_a;
    logic [3:0]  shift_b;
    logic        sel_a;
    logic        sel_b;
    logic        zero;
    logic        trunc;

    logic [27:0] outs;
    assign outs = {seg_a, shift_a, sel_a, seg_b, shift_b, sel_b, zero, trunc};

    dsm_segment_stage #(.WIDTH(16), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .seg_a     (seg_a),
        .seg_b     (seg_b),
        .shift_a   (shift_a),
        .shift_b   (shift_b),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .zero      (zero),
        .trunc     (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [27:0] q[$];
    bit          stalled = 1'b0;
    logic [27:0] prev_outs = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: leading one p via log2; window of 8 bits below and including p.
    function automatic void ref_op(input int x, output int sg, output int sh, output bit tr);
        int p;
        p = $clog2(x + 1) - 1;
        if (p < 8) begin
            sh = 0;
            sg = x;
            tr = 1'b0;
        end else begin
            sh = p - 7;
            sg = x / (1 << sh);
            tr = (x % (1 << sh)) != 0;
            if (tr) sg = sg | 1;
        end
    endfunction

    function automatic logic [27:0] model(input logic [15:0] xa, input logic [15:0] xb);
        int sga, sha, sgb, shb;
        bit ta, tb;
        ref_op(int'(xa), sga, sha, ta);
        ref_op(int'(xb), sgb, shb, tb);
        return {8'(sga), 4'(sha), sha != 0, 8'(sgb), 4'(shb), shb != 0,
                (xa == 16'd0) || (xb == 16'd0), ta | tb};
    endfunction

    function automatic logic [15:0] rnd_op();
        int w;
        w = $urandom_range(0, 16);
        return 16'($urandom) & 16'((32'd1 << w) - 32'd1);
    endfunction

    // Called at posedge+1 with inputs set; samples at posedge+2, then advances one edge.
    task automatic tick(output bit acc, output bit ret);
        logic [27:0] exp;
        #1;
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        if (stalled) begin
            chk("hold_vld", 32'(out_valid), 32'd1);
            chk("hold_dat", 32'(outs), 32'(prev_outs));
        end
        if (ret) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp = q.pop_front();
                chk("sb_data", 32'(outs), 32'(exp));
            end
        end
        if (acc) q.push_back(model(a, b));
        stalled   = out_valid && !out_ready;
        prev_outs = outs;
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(input string tag, input logic [15:0] xa,
                                  input logic [15:0] xb, input logic [27:0] exp);
        bit acc, ret;
        in_valid  = 1'b1;
        a         = xa;
        b         = xb;
        out_ready = 1'b1;
        tick(acc, ret);
        chk("dir_acc", 32'(acc), 32'd1);
        in_valid = 1'b0;
        chk("lat1_vld", 32'(out_valid), 32'd0);
        tick(acc, ret);
        chk("lat2_vld", 32'(out_valid), 32'd1);
        chk(tag, 32'(outs), 32'(exp));
        tick(acc, ret);
    endtask

    initial begin
        bit acc, ret;
        int sent, rcount, n, cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_dat", 32'(outs), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_and_check("vec_small", 16'h00B5, 16'h0003, {8'hB5, 4'd0, 1'b0, 8'h03, 4'd0, 1'b0, 1'b0, 1'b0});
        send_and_check("vec_trunc", 16'h0F0F, 16'h1234, {8'hF1, 4'd4, 1'b1, 8'h91, 4'd5, 1'b1, 1'b0, 1'b1});
        send_and_check("vec_zero",  16'h8000, 16'h0000, {8'h80, 4'd8, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0});
        send_and_check("vec_edge",  16'h00FF, 16'h0100, {8'hFF, 4'd0, 1'b0, 8'h80, 4'd1, 1'b1, 1'b0, 1'b0});
        send_and_check("vec_ones",  16'hFFFF, 16'h01FF, {8'hFF, 4'd8, 1'b1, 8'hFF, 4'd1, 1'b1, 1'b0, 1'b1});

        // Fill while stalled, then release and expect back-to-back retirement.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sent      = 0;
        for (int i = 0; i < 2; i++) begin
            a = rnd_op();
            b = rnd_op();
            tick(acc, ret);
            if (acc) sent++;
        end
        chk("fill_accepts", 32'(sent), 32'd2);
        chk("full_rdy", 32'(in_ready), 32'd0);
        a = rnd_op();
        b = rnd_op();
        tick(acc, ret);
        chk("full_no_acc", 32'(acc), 32'd0);
        out_ready = 1'b1;
        rcount    = 0;
        for (int i = 0; i < 8; i++) begin
            tick(acc, ret);
            if (ret) rcount++;
            if (acc) begin
                sent++;
                if (sent == 8) in_valid = 1'b0;
                a = rnd_op();
                b = rnd_op();
            end
        end
        chk("stream_sent", 32'(sent), 32'd8);
        chk("stream_b2b", 32'(rcount), 32'd8);
        chk("stream_empty", 32'(q.size()), 32'd0);

        // Random handshakes with scoreboard and stall-hold checking.
        n   = 0;
        cyc = 0;
        acc = 1'b0;
        in_valid = 1'b0;
        while (n < 10000 && cyc < 80000) begin
            if (!(in_valid && !acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = rnd_op();
                b = rnd_op();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick(acc, ret);
            if (acc) n++;
            cyc++;
        end
        chk("rand_done", 32'(n), 32'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick(acc, ret);
        chk("rand_drain", 32'(q.size()), 32'd0);

        // Asynchronous reset with both stages occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = rnd_op() | 16'h0001;
            b = rnd_op() | 16'h0001;
            tick(acc, ret);
        end
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_dat", 32'(outs), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        q.delete();
        stalled = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(acc, ret);
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        send_and_check("post_rst_vec", 16'h0F0F, 16'h1234, {8'hF1, 4'd4, 1'b1, 8'h91, 4'd5, 1'b1, 1'b0, 1'b1});
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
